// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem valid/ack request, hold until accepted
// Optional macro FETCH_MISALIGN_TRAP_EN: halt on a misaligned branch target instead of masking it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             PC_Src,
    input  logic [31:0]      ImmExt,
    output logic [CNT_W-1:0] retired_count,
    output logic             misalign
);

    typedef enum logic [1:0] {START, REQ, HOLD, HALT} state_t;

    localparam logic [31:0]      NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_next;
    logic        accept;
    logic        trap;
    logic [31:0] target_raw;
    logic [31:0] target;

    assign accept    = instr_valid && instr_ready;
    assign imem_addr = pc;

    always_comb begin
        target_raw = PC_Src ? (pc + ImmExt) : (pc + 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
        target = target_raw;
        trap   = |target_raw[1:0];
`else
        target = target_raw & 32'hFFFF_FFFC;
        trap   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= START;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            START:   state_next = REQ;
            REQ:     if (imem_ack) state_next = HOLD;
            HOLD:    if (accept) state_next = trap ? HALT : REQ;
            HALT:    state_next = HALT;
            default: state_next = START;
        endcase
    end

    // Acks are only honoured in REQ, so a stray or late pulse never disturbs the held instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            instr         <= NOP;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b0;
            retired_count <= '0;
        end else begin
            case (state)
                START: imem_req <= 1'b1;
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        pc            <= target;
                        instr_valid   <= 1'b0;
                        imem_req      <= !trap;
                        retired_count <= retired_count + CNT_ONE;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (state == HOLD && accept && trap)
            misalign_q <= 1'b1;
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a transaction-level reference model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        PC_Src;
    logic [31:0] ImmExt;
    logic [31:0] retired_count;
    logic        misalign;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PC_Src(PC_Src), .ImmExt(ImmExt),
        .retired_count(retired_count), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; PC_Src = 1'b0; ImmExt = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic mem_ack(input logic [31:0] data, input int lat);
        for (int i = 0; i < lat; i++) step();
        imem_ack = 1'b1; imem_rdata = data;
        step();
        imem_ack = 1'b0; imem_rdata = $urandom;
    endtask

    task automatic accept_instr(input logic src, input logic [31:0] imm);
        instr_ready = 1'b1; PC_Src = src; ImmExt = imm;
        step();
        instr_ready = 1'b0; PC_Src = $urandom_range(0, 1); ImmExt = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; PC_Src = 1'b0; ImmExt = '0; imem_rdata = '0;
        step();
        step();
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        n_cmp++; if (instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr got %h want %h", instr, 32'h13); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
        n_cmp++; if (retired_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", retired_count); end
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", misalign); end
        rst = 1'b0;
        step();
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i))
                begin n_fail++; $display("FAIL seq_addr[%0d] req %b addr %h want req 1 addr %h", i, imem_req, imem_addr, 4 * i); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_low[%0d] got %b want 0", i, instr_valid); end
            mem_ack(d, 0);
            n_cmp++; if (instr_valid !== 1'b1 || instr !== d || imem_req !== 1'b0)
                begin n_fail++; $display("FAIL seq_instr[%0d] valid %b instr %h req %b want 1 %h 0", i, instr_valid, instr, imem_req, d); end
            accept_instr(1'b0, $urandom);
        end
        n_cmp++; if (retired_count !== 32'd5) begin n_fail++; $display("FAIL seq_count got %0d want 5", retired_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        mem_ack(d, 1);
        for (int i = 0; i < 3; i++) begin
            PC_Src = $urandom_range(0, 1); ImmExt = $urandom;
            imem_ack = 1'b1; imem_rdata = ~d;
            step();
            imem_ack = 1'b0;
            n_cmp++; if (instr !== d || pc !== 32'h0 || instr_valid !== 1'b1 || imem_req !== 1'b0 || retired_count !== 32'd0)
                begin n_fail++; $display("FAIL bp_hold[%0d] instr %h pc %h valid %b req %b cnt %0d want %h 0 1 0 0", i, instr, pc, instr_valid, imem_req, retired_count, d); end
        end
        accept_instr(1'b0, 32'h0);
        n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4 || retired_count !== 32'd1)
            begin n_fail++; $display("FAIL bp_accept valid %b req %b addr %h cnt %0d want 0 1 4 1", instr_valid, imem_req, imem_addr, retired_count); end
    endtask

    task automatic test_branch();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ack($urandom, 0);
            accept_instr(1'b0, 32'h0);
        end
        n_cmp++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL br_pre_addr got %h want 10", imem_addr); end
        mem_ack($urandom, 0);
        accept_instr(1'b1, 32'hFFFF_FFF8);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL br_target req %b addr %h want 1 8", imem_req, imem_addr); end
        d = $urandom;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8)
                begin n_fail++; $display("FAIL br_wait[%0d] valid %b req %b addr %h want 0 1 8", i, instr_valid, imem_req, imem_addr); end
        end
        mem_ack(d, 0);
        n_cmp++; if (instr_valid !== 1'b1 || instr !== d) begin n_fail++; $display("FAIL br_latency valid %b instr %h want 1 %h", instr_valid, instr, d); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        mem_ack($urandom, 0);
        accept_instr(1'b1, 32'hFFFF_FFFC);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre got %h want fffffffc", imem_addr); end
        mem_ack($urandom, 0);
        accept_instr(1'b0, $urandom);
        n_cmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_addr addr %h req %b want 0 1", imem_addr, imem_req); end
        mem_ack(32'hDEAD_BEEF, 0);
        accept_instr(1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (pc !== 32'h0 || instr !== 32'h13 || retired_count !== 32'd0 || imem_req !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid pc %h instr %h cnt %0d req %b want 0 13 0 0", pc, instr, retired_count, imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        step();
        imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h13 || imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin n_fail++; $display("FAIL late_ack valid %b instr %h req %b addr %h want 0 13 1 0", instr_valid, instr, imem_req, imem_addr); end
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        rst = 1'b0; imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h13) begin n_fail++; $display("FAIL rst_prio valid %b instr %h want 0 13", instr_valid, instr); end
    endtask

    task automatic test_misalign();
        do_reset();
        mem_ack($urandom, 0);
        accept_instr(1'b1, 32'h6);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (misalign !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h6 || retired_count !== 32'd1)
                begin n_fail++; $display("FAIL misalign_halt[%0d] mis %b req %b valid %b pc %h cnt %0d want 1 0 0 6 1", i, misalign, imem_req, instr_valid, pc, retired_count); end
            imem_ack = 1'b1; instr_ready = 1'b1;
            step();
            imem_ack = 1'b0; instr_ready = 1'b0;
        end
`else
        n_cmp++; if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4)
            begin n_fail++; $display("FAIL misalign_mask mis %b req %b addr %h want 0 1 4", misalign, imem_req, imem_addr); end
`endif
    endtask

    // Reference model tracks PC, count and the word in flight at transaction level.
    task automatic test_random();
        logic [31:0] m_pc, m_instr, data;
        int          m_cnt, lat, stall;
        logic        src;
        logic [31:0] imm;
        do_reset();
        m_pc = 32'h0; m_cnt = 0; m_instr = 32'h13; lat = $urandom_range(0, 3); stall = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            n_cmp++; if (imem_req === 1'b1 && instr_valid === 1'b1) begin n_fail++; $display("FAIL rnd_overlap cyc %0d req and valid both high", cyc); end
            n_cmp++; if (pc !== m_pc || retired_count !== 32'(m_cnt))
                begin n_fail++; $display("FAIL rnd_state cyc %0d pc %h cnt %0d want %h %0d", cyc, pc, retired_count, m_pc, m_cnt); end
            if (instr_valid === 1'b1) begin
                n_cmp++; if (instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr cyc %0d got %h want %h", cyc, instr, m_instr); end
            end
            if (imem_req !== 1'b1 && instr_valid !== 1'b1) stall++;
            else stall = 0;
            if (stall > 2) begin
                n_fail++; n_cmp++;
                $display("FAIL rnd_progress cyc %0d neither req nor valid", cyc);
                break;
            end
            data = $urandom;
            src = $urandom_range(0, 1);
            imm = $urandom & 32'hFFFF_FFFC;
            imem_rdata = data;
            imem_ack = 1'b0;
            instr_ready = ($urandom_range(0, 1) == 1);
            PC_Src = src; ImmExt = imm;
            if (imem_req === 1'b1) begin
                if (lat == 0) begin
                    imem_ack = 1'b1;
                    m_instr = data;
                end else lat--;
            end else begin
                imem_ack = ($urandom_range(0, 3) == 0);
                if (instr_valid === 1'b1 && instr_ready) begin
                    m_pc = src ? (m_pc + imm) : (m_pc + 32'd4);
                    m_cnt++;
                    lat = $urandom_range(0, 3);
                end
            end
            step();
        end
        imem_ack = 1'b0; instr_ready = 1'b0;
        n_cmp++; if (m_cnt < 50) begin n_fail++; $display("FAIL rnd_volume retired %0d want at least 50", m_cnt); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_wrap_and_reset();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of `Control_unit` in the RISC-V core. It owns the program counter and requests instructions from instruction memory over a valid/ack handshake. It holds each fetched instruction until the control unit and datapath accept it, then computes the next PC from the `PC_Src`/`ImmExt` pair that downstream produced for the accepted instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `CNT_W`, 32, width of the retired-instruction counter

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous and active-high
- `imem_req`  out  1  fetch request; registered; held high until `imem_ack`
- `imem_addr`  out  32  fetch address; equals `pc`; stable while `imem_req` is high
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` is valid in the same cycle
- `imem_rdata`  in  32  instruction word from memory
- `instr`  out  32  registered instruction presented to decode (`op_code` = `instr[6:0]`)
- `pc`  out  32  address of `instr`
- `instr_valid`  out  1  `instr` is valid and waiting for acceptance
- `instr_ready`  in  1  downstream accepts `instr` when high together with `instr_valid`
- `PC_Src`  in  1  1 = take branch target; sampled only on acceptance
- `ImmExt`  in  32  sign-extended branch offset; sampled only on acceptance
- `retired_count`  out  `CNT_W`  number of accepted instructions
- `misalign`  out  1  misaligned branch target detected (see Configuration)

## Operation
- The state machine has four states: START, REQ, HOLD and HALT.
- Reset values:
  - `pc` = `RESET_PC`, `instr` = 32'h0000_0013 (NOP)
  - `instr_valid` = 0, `imem_req` = 0
  - `retired_count` = 0, `misalign` = 0
  - state = START
- START: moves unconditionally to REQ on the next edge and sets `imem_req` = 1.
- REQ: `imem_req` = 1 and `imem_addr` = `pc`. On `imem_ack`:
  - latch `imem_rdata` into `instr`
  - set `instr_valid` = 1 and `imem_req` = 0
  - go to HOLD
- HOLD: `instr`, `pc` and `instr_valid` are held stable. On `instr_valid && instr_ready` (acceptance):
  - compute the target: `pc + ImmExt` if `PC_Src`, else `pc + 4`
  - `pc` <= target
  - `instr_valid` <= 0, `imem_req` <= 1
  - `retired_count` <= `retired_count` + 1
  - go to REQ
- Arithmetic:
  - all PC arithmetic is modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0
  - `retired_count` wraps modulo 2^`CNT_W`
- `imem_ack` outside REQ is ignored. A stray or late ack must not change any state.
- `PC_Src` and `ImmExt` are don't-care outside acceptance cycles.
- HALT: `imem_req` = 0, `instr_valid` = 0 and `misalign` = 1. Only `rst` leaves HALT.

## Timing
- Throughput with a zero-wait memory (ack in the first REQ cycle) and `instr_ready` tied high: one instruction every 2 cycles.
- Fetch latency: `instr_valid` rises on the edge after `imem_ack`.
- The first `imem_req` is asserted one cycle after the last cycle in which `rst` is high.
- `rst` asserted mid-request or mid-hold:
  - all outputs return to their reset values on that edge
  - the outstanding request is abandoned
  - an ack arriving afterwards is ignored because the state is then START
- `rst` takes priority over acceptance and over ack in the same cycle.
- Acceptance and the next request never overlap. `imem_req` is 0 in every cycle where `instr_valid` is 1.

## Configuration
- Macro `FETCH_MISALIGN_TRAP_EN`.
- Defined: if an accepted target has bit 1 or bit 0 set:
  - `pc` still loads the target
  - the state goes to HALT and `misalign` = 1
  - no request is issued
  - `retired_count` still increments for the accepted instruction
- Undefined:
  - bits [1:0] of every target are forced to 2'b00
  - `misalign` is tied to 0
  - HALT is unreachable

## Test plan
- Reset: hold `rst` high for 2 cycles -> `pc`=0, `instr`=0x00000013, `instr_valid`=0, `imem_req`=0; the cycle after `rst` falls, `imem_req`=1 and `imem_addr`=0.
- Sequential fetch: zero-wait memory, `instr_ready`=1, `PC_Src`=0 for 5 instructions -> `imem_addr` sequence 0,4,8,0xC,0x10; `instr_valid` pulses every 2nd cycle; `retired_count`=5.
- Backpressure: `instr_ready`=0 for 3 cycles in HOLD -> `instr`/`pc` stable, `imem_req`=0, `retired_count` unchanged; accepted on the 4th cycle.
- Branch: accept at `pc`=0x10 with `PC_Src`=1 and `ImmExt`=0xFFFF_FFF8 -> next `imem_addr`=0x08. A memory with 3-cycle ack latency -> `instr_valid` rises exactly 1 cycle after the ack.
- Wrap and reset mid-op: `pc`=0xFFFF_FFFC accepted with `PC_Src`=0 -> next `imem_addr`=0. Assert `rst` while REQ is waiting, then ack one cycle later -> ack ignored, `pc`=`RESET_PC`.
- Misalign: accept with `PC_Src`=1, `ImmExt`=0x6 at `pc`=0 -> with the macro, `misalign`=1 and `imem_req` stays 0; without it, `imem_addr`=0x4.
